// File: rtl/pipe_pkg.sv
// Shared fetch/decode pipeline definitions: packet layout, reset level, constants.
package pipe_pkg;

  // Packet field widths used by the default 32-bit fetch path.
  localparam int PKT_PC_W   = 32;
  localparam int PKT_INST_W = 32;

  // Reset is active-low throughout the fetch/decode slice.
  localparam logic RstEnable = 1'b0;

  // All-zero word; an all-zero instruction is treated as a bubble downstream.
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef struct packed {
    logic [PKT_PC_W-1:0]   pc;
    logic [PKT_INST_W-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/pipe_fifo_mem.sv
// Register array for the IF/ID elastic buffer: one write port, one async read port.
module pipe_fifo_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage holds data only, so it is written without any reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_elastic.sv
// Elastic IF/ID stage: circular buffer of up to DEPTH fetch packets with
// valid/ready on both sides; stall is back-pressure, flush drops everything.
module if_id_elastic
  import pipe_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int DATA_W = PC_W + INST_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Same layout as fetch_pkt_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } pkt_t;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  pkt_t             wr_pkt;
  pkt_t             rd_pkt;

  // in_ready comes only from the registered count, so a pop cannot open a
  // slot for a push in the same cycle; this keeps out_ready off the in_ready path.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign wr_pkt.pc   = in_pc;
  assign wr_pkt.inst = in_inst;

  pipe_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_pkt),
    .rd_addr (rd_ptr),
    .rd_data (rd_pkt)
  );

  // Head packet is gated to zero when empty so stale storage never reaches decode.
  assign out_pc   = out_valid ? rd_pkt.pc   : '0;
  assign out_inst = out_valid ? rd_pkt.inst : '0;

  // Pointer and occupancy control; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_elastic.sv
// Directed bench for if_id_elastic: a DEPTH=2 instance for handshake, flush
// and reset behaviour, and a DEPTH=4 / PC_W=16 instance for pointer wrap.
module tb_if_id_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2, 32-bit instance
  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_pc, a_in_inst, a_out_pc, a_out_inst;
  logic [1:0]  a_count;

  // DEPTH=4, PC_W=16 instance
  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_pc, b_out_pc;
  logic [31:0] b_in_inst, b_out_inst;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;

  if_id_elastic #(.PC_W(32), .INST_W(32), .DEPTH(2)) dut_a (
    .clk       (clk),
    .rst       (a_rst),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_pc     (a_in_pc),
    .in_inst   (a_in_inst),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_pc    (a_out_pc),
    .out_inst  (a_out_inst),
    .count     (a_count)
  );

  if_id_elastic #(.PC_W(16), .INST_W(32), .DEPTH(4)) dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_pc     (b_in_pc),
    .in_inst   (b_in_inst),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_pc    (b_out_pc),
    .out_inst  (b_out_inst),
    .count     (b_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction tag derived from pc so a pc/inst mix-up is visible.
  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'h1300_0013;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_offer(input logic v, input logic [31:0] pc);
    a_in_valid = v;
    a_in_pc    = pc;
    a_in_inst  = ins(pc);
  endtask

  task automatic a_head(input string tag, input logic v, input logic [31:0] pc, input logic [1:0] cnt);
    chk({tag, "_valid"}, 64'(a_out_valid), 64'(v));
    chk({tag, "_pc"},    64'(a_out_pc),    64'(v ? pc : 32'h0));
    chk({tag, "_inst"},  64'(a_out_inst),  64'(v ? ins(pc) : 32'h0));
    chk({tag, "_count"}, 64'(a_count),     64'(cnt));
  endtask

  initial begin
    a_rst = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    a_offer(1'b1, 32'h99);
    b_rst = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_pc = '0; b_in_inst = '0;
    #1;

    // Reset held two cycles with fetch offering a packet
    step();
    step();
    a_head("rst", 1'b0, 32'h0, 2'd0);
    a_rst = 1'b1;
    a_offer(1'b0, 32'h0);
    step();
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    a_head("rst_rel", 1'b0, 32'h0, 2'd0);

    // Streaming at full throughput
    a_out_ready = 1'b1;
    a_offer(1'b1, 32'h00); step(); a_head("st0", 1'b1, 32'h00, 2'd1);
    a_offer(1'b1, 32'h04); step(); a_head("st1", 1'b1, 32'h04, 2'd1);
    a_offer(1'b1, 32'h08); step(); a_head("st2", 1'b1, 32'h08, 2'd1);
    a_offer(1'b0, 32'h00); step(); a_head("st_end", 1'b0, 32'h0, 2'd0);

    // Back-pressure: fill, hold 0x18 at fetch, then drain in order
    a_out_ready = 1'b0;
    a_offer(1'b1, 32'h10); step(); a_head("bp0", 1'b1, 32'h10, 2'd1);
    a_offer(1'b1, 32'h14); step(); a_head("bp1", 1'b1, 32'h10, 2'd2);
    chk("bp_full_ready", 64'(a_in_ready), 64'd0);
    a_offer(1'b1, 32'h18); step(); a_head("bp_hold", 1'b1, 32'h10, 2'd2);
    a_out_ready = 1'b1;
    step(); a_head("bp_pop0", 1'b1, 32'h14, 2'd1);
    chk("bp_ready_back", 64'(a_in_ready), 64'd1);
    step(); a_head("bp_pop1", 1'b1, 32'h18, 2'd1);
    a_offer(1'b0, 32'h0);
    step(); a_head("bp_empty", 1'b0, 32'h0, 2'd0);

    // Flush with one held and a packet offered: offered packet must be dropped
    a_out_ready = 1'b0;
    a_offer(1'b1, 32'h30); step(); a_head("fl_pre", 1'b1, 32'h30, 2'd1);
    a_flush = 1'b1;
    a_offer(1'b1, 32'h20); step(); a_head("fl_part", 1'b0, 32'h0, 2'd0);
    a_flush = 1'b0;
    a_offer(1'b0, 32'h0); step(); a_head("fl_part2", 1'b0, 32'h0, 2'd0);

    // Flush with a full buffer
    a_offer(1'b1, 32'h40); step();
    a_offer(1'b1, 32'h44); step(); a_head("flf_pre", 1'b1, 32'h40, 2'd2);
    a_flush = 1'b1;
    a_offer(1'b1, 32'h20); step(); a_head("flf", 1'b0, 32'h0, 2'd0);
    a_flush = 1'b0;
    a_offer(1'b1, 32'h48); step(); a_head("flf_post", 1'b1, 32'h48, 2'd1);

    // Flush together with reset
    a_rst = 1'b0; a_flush = 1'b1;
    a_offer(1'b1, 32'h4c); step(); a_head("flrst", 1'b0, 32'h0, 2'd0);
    a_rst = 1'b1; a_flush = 1'b0;
    a_offer(1'b0, 32'h0); step(); a_head("flrst_rel", 1'b0, 32'h0, 2'd0);

    // Simultaneous push and pop at count 1
    a_offer(1'b1, 32'h60); step(); a_head("pp_pre", 1'b1, 32'h60, 2'd1);
    a_out_ready = 1'b1;
    a_offer(1'b1, 32'h64); step(); a_head("pp", 1'b1, 32'h64, 2'd1);
    a_out_ready = 1'b0;
    a_offer(1'b1, 32'h68); step(); a_head("pp_fill", 1'b1, 32'h64, 2'd2);

    // Reset mid-operation with a full buffer
    a_rst = 1'b0;
    a_offer(1'b0, 32'h0); step(); a_head("mrst", 1'b0, 32'h0, 2'd0);
    a_rst = 1'b1; step();
    chk("mrst_in_ready", 64'(a_in_ready), 64'd1);

    // DEPTH=4: fill 4 / drain 4, three rounds, exercising pointer wrap
    step();
    b_rst = 1'b1;
    step();
    chk("b_rst_count", 64'(b_count), 64'd0);
    for (int r = 0; r < 3; r++) begin
      b_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        b_in_valid = 1'b1;
        b_in_pc    = 16'(16'h100 * r + 4 * i);
        b_in_inst  = ins(32'(b_in_pc));
        step();
        chk($sformatf("b_fill_r%0d_cnt", r), 64'(b_count), 64'(i + 1));
      end
      b_in_valid = 1'b0;
      chk($sformatf("b_full_r%0d_ready", r), 64'(b_in_ready), 64'd0);
      b_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b_r%0d_pc%0d", r, i), 64'(b_out_pc), 64'(16'h100 * r + 4 * i));
        chk($sformatf("b_r%0d_inst%0d", r, i), 64'(b_out_inst), 64'(ins(32'(16'h100 * r + 4 * i))));
        step();
        chk($sformatf("b_drain_r%0d_cnt", r), 64'(b_count), 64'(3 - i));
      end
      chk($sformatf("b_empty_r%0d_valid", r), 64'(b_out_valid), 64'd0);
      chk($sformatf("b_empty_r%0d_pc", r), 64'(b_out_pc), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
